// File: rtl/gmac_tx_pkg.sv
// Shared types and helpers for the GMAC TX arbitration path.
package gmac_tx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      XFER  = 3'd2,
      DRAIN = 3'd3,
      GAP   = 3'd4
   } tx_state_t;

   localparam logic [15:0] DROP_SAT = 16'hFFFF;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 0;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin select: first requester at or after ptr+1 (mod N).
module rr_arbiter_n
   import gmac_tx_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = clog2(N)
)(
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW-1:0] w_cand;

   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         w_cand = IW'((32'(i_ptr) + k) % N);
         if (!o_any && i_req[w_cand]) begin
            o_any = 1'b1;
            o_idx = w_cand;
         end
      end
      if (o_any) o_gnt = N'(1) << o_idx;
   end

endmodule

// File: rtl/gmac_tx_arbiter_n.sv
// N-channel GMAC TX frame arbiter: round-robin grant, grant timeout,
// max-length truncation, inter-frame gap and link-down abort.
module gmac_tx_arbiter_n
   import gmac_tx_pkg::*;
#(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned IFG_CYCLES = 12,
   parameter int unsigned GRANT_TMO  = 1024,
   parameter int unsigned MAX_LEN    = 1514,
   parameter int unsigned CW         = 16
)(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              LINK_UP,
   input  logic [N_CH-1:0]   ReqIn,
   input  logic [N_CH-1:0]   ValIn,
   input  logic [N_CH-1:0]   SoFIn,
   input  logic [N_CH-1:0]   EoFIn,
   input  logic [8*N_CH-1:0] DataIn,
   output logic [N_CH-1:0]   ReqConfirm,
   output logic              ValOut,
   output logic              SoFOut,
   output logic              EoFOut,
   output logic              ErrOut,
   output logic [7:0]        DataOut,
   output logic [2:0]        GrantCh,
   output logic [15:0]       DropCnt
);

   localparam int unsigned   IW       = clog2(N_CH);
   localparam logic [CW-1:0] TMO_LAST = CW'(GRANT_TMO - 1);
   localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);
   localparam logic [CW-1:0] LEN_MAX  = CW'(MAX_LEN);

   tx_state_t       r_state, w_state;
   logic [IW-1:0]   r_ptr, w_ptr, r_gch, w_gch;
   logic [N_CH-1:0] r_rc, w_rc;
   logic [CW-1:0]   r_cnt, w_cnt, r_len, w_len;
   logic            r_val, w_val, r_sof, w_sof, r_eof, w_eof, r_err, w_err;
   logic [7:0]      r_data, w_data;
   logic [15:0]     r_drop, w_drop, w_drop_inc;

   logic [N_CH-1:0] w_arb_gnt;
   logic [IW-1:0]   w_arb_idx;
   logic            w_arb_any;
   logic            w_ch_val, w_ch_sof, w_ch_eof;
   logic [7:0]      w_ch_data;

   rr_arbiter_n #(.N(N_CH), .IW(IW)) u_rr (
      .i_req (ReqIn),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_any (w_arb_any)
   );

   assign w_ch_val   = ValIn[r_gch];
   assign w_ch_sof   = SoFIn[r_gch];
   assign w_ch_eof   = EoFIn[r_gch];
   assign w_ch_data  = DataIn[8*r_gch +: 8];
   assign w_drop_inc = (r_drop == DROP_SAT) ? r_drop : r_drop + 16'd1;

   always_comb begin
      w_state = r_state;
      w_ptr   = r_ptr;
      w_gch   = r_gch;
      w_rc    = r_rc;
      w_cnt   = r_cnt;
      w_len   = r_len;
      w_val   = 1'b0;
      w_sof   = 1'b0;
      w_eof   = 1'b0;
      w_err   = 1'b0;
      w_data  = '0;
      w_drop  = r_drop;
      case (r_state)
         IDLE: begin
            w_rc = '0;
            if (LINK_UP && w_arb_any) begin
               w_rc    = w_arb_gnt;
               w_gch   = w_arb_idx;
               w_cnt   = '0;
               w_state = GRANT;
            end
         end
         GRANT, XFER: begin
            if (!LINK_UP) begin
               if (r_state == XFER) begin
                  // abort marker beat; the rest of the source frame is swallowed in DRAIN
                  w_val   = 1'b1;
                  w_eof   = 1'b1;
                  w_err   = 1'b1;
                  w_drop  = w_drop_inc;
                  w_state = DRAIN;
               end else begin
                  w_rc    = '0;
                  w_state = IDLE;
               end
            end else if (w_ch_val && (r_state == XFER || w_ch_sof)) begin
               w_val  = 1'b1;
               w_sof  = w_ch_sof;
               w_eof  = w_ch_eof;
               w_data = w_ch_data;
               w_len  = (r_state == GRANT) ? CW'(1) : r_len + CW'(1);
               if (w_ch_eof) begin
                  w_rc    = '0;
                  w_ptr   = r_gch;
                  w_cnt   = '0;
                  w_state = GAP;
               end else if (w_len == LEN_MAX) begin
                  w_eof   = 1'b1;
                  w_err   = 1'b1;
                  w_drop  = w_drop_inc;
                  w_state = DRAIN;
               end else begin
                  w_state = XFER;
               end
            end else if (r_state == GRANT) begin
               if (r_cnt == TMO_LAST) begin
                  w_rc    = '0;
                  w_ptr   = r_gch;
                  w_drop  = w_drop_inc;
                  w_state = IDLE;
               end else begin
                  w_cnt = r_cnt + CW'(1);
               end
            end
         end
         DRAIN: begin
            if (w_ch_val && w_ch_eof) begin
               w_rc    = '0;
               w_ptr   = r_gch;
               w_cnt   = '0;
               w_state = GAP;
            end
         end
         GAP: begin
            if (r_cnt == IFG_LAST) w_state = IDLE;
            else                   w_cnt   = r_cnt + CW'(1);
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_gch   <= '0;
         r_rc    <= '0;
         r_cnt   <= '0;
         r_len   <= '0;
         r_val   <= 1'b0;
         r_sof   <= 1'b0;
         r_eof   <= 1'b0;
         r_err   <= 1'b0;
         r_data  <= '0;
         r_drop  <= '0;
      end else begin
         r_state <= w_state;
         r_ptr   <= w_ptr;
         r_gch   <= w_gch;
         r_rc    <= w_rc;
         r_cnt   <= w_cnt;
         r_len   <= w_len;
         r_val   <= w_val;
         r_sof   <= w_sof;
         r_eof   <= w_eof;
         r_err   <= w_err;
         r_data  <= w_data;
         r_drop  <= w_drop;
      end
   end

   assign ReqConfirm = r_rc;
   assign ValOut     = r_val;
   assign SoFOut     = r_sof;
   assign EoFOut     = r_eof;
   assign ErrOut     = r_err;
   assign DataOut    = r_data;
   assign GrantCh    = 3'(r_gch);
   assign DropCnt    = r_drop;

endmodule

// File: doc/gmac_tx_arbiter_n.md
Name: gmac_tx_arbiter_n

Overview:
- N-channel transmit frame arbiter for the GMAC TX path.
- Sits between the frame sources (ARP responder, user UDP sources) and the L2 output/CRC/RGMII serializer.
- Generalises the fixed two-input Req/ReqConfirm merge:
  - parametrised channel count;
  - round-robin fairness;
  - grant timeout;
  - maximum-frame-length guard;
  - programmable inter-frame gap;
  - link-down abort.

Parameters:
- N_CH, 4, number of source channels (2..8).
- IFG_CYCLES, 12, idle Clk cycles forced between output frames (>=1).
- GRANT_TMO, 1024, cycles a granted channel may take to present SoF before the grant is revoked.
- MAX_LEN, 1514, maximum bytes per frame before forced truncation.
- CW, 16, width of the internal byte/timeout counters (must hold MAX_LEN and GRANT_TMO).

Ports:
- Clk  in  1  system clock, 125 MHz domain.
- Rst  in  1  asynchronous, active-high reset.
- LINK_UP  in  1  PHY link status; grants are only issued while high.
- ReqIn  in  N_CH  per-channel transmit request, level, held until ReqConfirm.
- ValIn  in  N_CH  per-channel byte valid.
- SoFIn  in  N_CH  per-channel first-byte marker (qualified by ValIn).
- EoFIn  in  N_CH  per-channel last-byte marker (qualified by ValIn).
- DataIn  in  8*N_CH  per-channel byte; channel i occupies [8i+7:8i].
- ReqConfirm  out  N_CH  one-hot grant.
- ValOut  out  1  merged byte valid.
- SoFOut  out  1  merged SoF.
- EoFOut  out  1  merged EoF.
- ErrOut  out  1  frame-abort flag, asserted with EoFOut.
- DataOut  out  8  merged byte.
- GrantCh  out  3  index of the current or last granted channel.
- DropCnt  out  16  saturating count of timeouts, truncations and link aborts.

Behaviour:
- Reset values: every output is 0; round-robin pointer is 0; state is IDLE.
- States: IDLE, GRANT, XFER, DRAIN, GAP.

IDLE:
- When LINK_UP=1 and any ReqIn is set, select the first requesting channel at or after ptr+1 (mod N_CH).
- Set ReqConfirm one-hot for that channel, load GrantCh, clear the timeout counter, go to GRANT.
- Arbitration takes 1 cycle; ReqConfirm is registered.

GRANT:
- Wait for ValIn&SoFIn on the granted channel.
  - On that beat, go to XFER and forward the byte (this includes a 1-byte frame with SoF+EoF on the same beat, which goes straight to GAP).
- If the timeout counter reaches GRANT_TMO-1 first:
  - drop ReqConfirm, set ptr to the granted channel, increment DropCnt, go to IDLE;
  - no output beat is generated.
- Val beats without SoF in GRANT are ignored.

XFER:
- Each ValIn beat of the granted channel is registered to the outputs with 1-cycle latency; SoF, EoF and Data pass through.
- Beats on ungranted channels are ignored at all times.
- The byte counter increments per forwarded beat.
- EoF beat: drop ReqConfirm on the following cycle, set ptr to the granted channel, go to GAP.
- Byte count reaches MAX_LEN without EoF:
  - force EoFOut=1 and ErrOut=1 on the MAX_LEN-th byte;
  - increment DropCnt, go to DRAIN.
- LINK_UP falls mid-frame:
  - emit a single ValOut=1, EoFOut=1, ErrOut=1 beat carrying DataOut=0;
  - increment DropCnt, go to DRAIN.

DRAIN:
- ReqConfirm stays asserted, and the channel's bytes are swallowed until its EoF beat.
- Then drop ReqConfirm and go to GAP.
- A further SoF seen in DRAIN is also swallowed.

GAP:
- Count IFG_CYCLES cycles with all outputs 0, then go to IDLE.
- Requests are not sampled during GAP.

General rules:
- ValOut, SoFOut, EoFOut and ErrOut are single-cycle pulses.
- DataOut is 0 whenever ValOut=0.
- DropCnt saturates at 16'hFFFF.
- LINK_UP=0 in IDLE, GRANT or GAP: no new grant is issued, and GRANT falls back to IDLE with no DropCnt increment.
- Reset asserted mid-frame clears everything immediately; no EoF is generated.

Decomposition:
- gmac_tx_pkg holds:
  - the state enum (IDLE, GRANT, XFER, DRAIN, GAP);
  - the DropCnt saturation constant;
  - the channel-index width function clog2(N_CH).
- One sub-module, rr_arbiter_n: combinational round-robin priority select (req vector, ptr) -> one-hot grant plus index. It is reused by future RX demux blocks.

Test Plan:
- N_CH=4, ch1 and ch3 request together after reset (ptr=0):
  - ch1 granted first, 64-byte frame out with 1-cycle latency;
  - 12 idle cycles, then ch3 granted;
  - then ch1 again if it re-requests.
- ch2 granted, no SoF for 1024 cycles:
  - ReqConfirm[2] drops at cycle 1024, DropCnt=1, no ValOut;
  - next requester is granted.
- ch0 sends a 1600-byte frame with MAX_LEN=1514:
  - byte 1514 emitted with EoFOut=ErrOut=1;
  - remaining 86 bytes swallowed, ReqConfirm[0] held until its EoF;
  - DropCnt increments by 1.
- LINK_UP deasserted at byte 20:
  - next cycle a single EoFOut=ErrOut=1 beat with DataOut=0;
  - no grants until LINK_UP=1 again.
- Single-byte frame (SoF+EoF same beat, data 8'hA5) on ch3:
  - one output beat with SoF=EoF=1, DataOut=8'hA5;
  - GAP entered directly.
- Ungranted ch1 drives ValIn during ch0's frame: output carries only ch0 bytes, in order and uncorrupted.
